// File: rtl/grey_step_decoder_pkg.sv
// Shared types and helpers for the Gray-coded LED bus (counter tile and decoder).
package grey_step_decoder_pkg;

  localparam int unsigned GRAY_MAX_W = 32;

  typedef enum logic {
    ST_ACQ  = 1'b0,
    ST_LOCK = 1'b1
  } state_e;

  localparam logic DIR_UP = 1'b1;
  localparam logic DIR_DN = 1'b0;

  // Gray to binary; zero-extended narrower words convert correctly.
  function automatic logic [GRAY_MAX_W-1:0] gray2bin(input logic [GRAY_MAX_W-1:0] g);
    logic [GRAY_MAX_W-1:0] b;
    b[GRAY_MAX_W-1] = g[GRAY_MAX_W-1];
    for (int i = GRAY_MAX_W - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

endpackage

// File: rtl/grey_step_decoder_sync.sv
// WIDTH x STAGES synchronizer bank for the asynchronous Gray word.
module grey_step_decoder_sync #(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] r_stage [STAGES];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(STAGES); i++) begin
        r_stage[i] <= '0;
      end
    end else begin
      r_stage[0] <= i_d;
      for (int i = 1; i < int'(STAGES); i++) begin
        r_stage[i] <= r_stage[i-1];
      end
    end
  end

  assign o_q = r_stage[STAGES-1];

endmodule

// File: rtl/grey_step_decoder.sv
// Gray bus receiver: synchronize, validate +/-1 steps, lock on a direction, emit counts.
module grey_step_decoder
  import grey_step_decoder_pkg::*;
#(
  parameter int unsigned WIDTH       = 8,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned LOCK_COUNT  = 4,
  parameter int unsigned ERR_CNT_W   = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [WIDTH-1:0]     gray_in,
  output logic [WIDTH-1:0]     bin_out,
  output logic                 bin_valid,
  output logic                 dir,
  output logic                 locked,
  output logic                 step_err,
  output logic [ERR_CNT_W-1:0] err_cnt
);

  localparam int unsigned RUN_W = $clog2(LOCK_COUNT + 1);

  logic [WIDTH-1:0]     w_g_s;
  logic [WIDTH-1:0]     r_g_prev;
  logic [WIDTH-1:0]     w_b_new;
  logic [WIDTH-1:0]     w_b_old;
  logic                 w_change;
  logic                 w_up;
  logic                 w_dn;
  logic                 w_legal;
  logic                 w_step_dir;
  logic [RUN_W-1:0]     w_run_inc;

  state_e               r_state;
  logic [RUN_W-1:0]     r_run;
  logic [WIDTH-1:0]     r_bin_out;
  logic                 r_bin_valid;
  logic                 r_dir;
  logic                 r_locked;
  logic                 r_step_err;
  logic [ERR_CNT_W-1:0] r_err_cnt;

  grey_step_decoder_sync #(
    .WIDTH  (WIDTH),
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .i_d   (gray_in),
    .o_q   (w_g_s)
  );

  // Change detect and step classification against the last seen word.
  assign w_change   = (w_g_s != r_g_prev);
  assign w_b_new    = WIDTH'(gray2bin(GRAY_MAX_W'(w_g_s)));
  assign w_b_old    = WIDTH'(gray2bin(GRAY_MAX_W'(r_g_prev)));
  assign w_up       = (w_b_new == WIDTH'(w_b_old + WIDTH'(1)));
  assign w_dn       = (w_b_new == WIDTH'(w_b_old - WIDTH'(1)));
  assign w_legal    = w_up | w_dn;
  assign w_step_dir = w_up ? DIR_UP : DIR_DN;
  assign w_run_inc  = RUN_W'(r_run + RUN_W'(1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_ACQ;
      r_g_prev    <= '0;
      r_run       <= '0;
      r_bin_out   <= '0;
      r_bin_valid <= 1'b0;
      r_dir       <= 1'b0;
      r_locked    <= 1'b0;
      r_step_err  <= 1'b0;
      r_err_cnt   <= '0;
    end else begin
      r_bin_valid <= 1'b0;
      r_step_err  <= 1'b0;
      if (w_change) begin
        r_g_prev <= w_g_s;
        case (r_state)
          ST_ACQ: begin
            if (!w_legal) begin
              r_run <= '0;
            end else if ((r_run == '0) || (w_step_dir == r_dir)) begin
              r_run <= w_run_inc;
              r_dir <= w_step_dir;
              if (w_run_inc == RUN_W'(LOCK_COUNT)) begin
                r_state     <= ST_LOCK;
                r_bin_out   <= w_b_new;
                r_bin_valid <= 1'b1;
                r_locked    <= 1'b1;
              end
            end else begin
              // Reversal restarts the run counting this step as the first.
              r_run <= RUN_W'(1);
              r_dir <= w_step_dir;
              if (LOCK_COUNT == 1) begin
                r_state     <= ST_LOCK;
                r_bin_out   <= w_b_new;
                r_bin_valid <= 1'b1;
                r_locked    <= 1'b1;
              end
            end
          end
          ST_LOCK: begin
            if (w_legal && (w_step_dir == r_dir)) begin
              r_bin_out   <= w_b_new;
              r_bin_valid <= 1'b1;
            end else begin
              r_step_err <= 1'b1;
              if (r_err_cnt != '1) begin
                r_err_cnt <= ERR_CNT_W'(r_err_cnt + ERR_CNT_W'(1));
              end
              r_run    <= '0;
              r_locked <= 1'b0;
              r_state  <= ST_ACQ;
            end
          end
          default: r_state <= ST_ACQ;
        endcase
      end
    end
  end

  assign bin_out   = r_bin_out;
  assign bin_valid = r_bin_valid;
  assign dir       = r_dir;
  assign locked    = r_locked;
  assign step_err  = r_step_err;
  assign err_cnt   = r_err_cnt;

endmodule

// File: tb/tb_grey_step_decoder.sv
// Scoreboard bench for grey_step_decoder: directed scenarios plus random walk.
module tb_grey_step_decoder;

  localparam int unsigned WIDTH = 8;
  localparam int unsigned LOCKN = 4;
  localparam int unsigned ERR_W = 4;
  localparam int          ERR_MAX = 15;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [WIDTH-1:0] gray_in = '0;
  logic [WIDTH-1:0] bin_out;
  logic             bin_valid;
  logic             dir;
  logic             locked;
  logic             step_err;
  logic [ERR_W-1:0] err_cnt;

  grey_step_decoder #(
    .WIDTH       (WIDTH),
    .SYNC_STAGES (2),
    .LOCK_COUNT  (LOCKN),
    .ERR_CNT_W   (ERR_W)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .gray_in   (gray_in),
    .bin_out   (bin_out),
    .bin_valid (bin_valid),
    .dir       (dir),
    .locked    (locked),
    .step_err  (step_err),
    .err_cnt   (err_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit is_err;
    int bin;
    int dir;
    int errs;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad   = 0;

  // Reference state: the count on the pins as plain integers.
  int m_prev = 0;
  int m_run = 0;
  int m_dir = 0;
  int m_locked = 0;
  int m_errs = 0;
  int m_last_bin = 0;
  int cur = 0;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_prev = 0; m_run = 0; m_dir = 0; m_locked = 0; m_errs = 0; m_last_bin = 0;
  endtask

  task automatic model_step(input int v);
    int d;
    int sd;
    bit legal;
    exp_t e;
    d = (v - m_prev) & 255;
    if (d == 0) return;
    legal = (d == 1) || (d == 255);
    sd = (d == 1) ? 1 : 0;
    m_prev = v;
    if (!m_locked) begin
      if (!legal) m_run = 0;
      else begin
        if (m_run == 0 || sd == m_dir) m_run++;
        else m_run = 1;
        m_dir = sd;
        if (m_run >= LOCKN) begin
          m_locked = 1;
          m_last_bin = v;
          e = '{is_err: 1'b0, bin: v, dir: m_dir, errs: m_errs};
          q.push_back(e);
        end
      end
    end else if (legal && sd == m_dir) begin
      m_last_bin = v;
      e = '{is_err: 1'b0, bin: v, dir: m_dir, errs: m_errs};
      q.push_back(e);
    end else begin
      if (m_errs < ERR_MAX) m_errs++;
      m_run = 0;
      m_locked = 0;
      e = '{is_err: 1'b1, bin: m_last_bin, dir: m_dir, errs: m_errs};
      q.push_back(e);
    end
  endtask

  // Put a new count on the pins and hold it for three clocks.
  task automatic drive(input int v);
    logic [WIDTH-1:0] b;
    @(negedge clk);
    b = WIDTH'(v);
    gray_in = b ^ (b >> 1);
    cur = v & 255;
    model_step(cur);
    repeat (3) @(posedge clk);
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_bin_out"}, int'(bin_out), 0);
    chk({tag, "_bin_valid"}, int'(bin_valid), 0);
    chk({tag, "_dir"}, int'(dir), 0);
    chk({tag, "_locked"}, int'(locked), 0);
    chk({tag, "_step_err"}, int'(step_err), 0);
    chk({tag, "_err_cnt"}, int'(err_cnt), 0);
  endtask

  // Monitor: every output pulse must match the next expected event.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (rst_n && (bin_valid || step_err)) begin
        if (bin_valid && step_err) begin
          chk("valid_and_err_both", 1, 0);
        end else if (q.size() == 0) begin
          chk("unexpected_pulse", int'(bin_out), -1);
        end else begin
          e = q.pop_front();
          chk("pulse_kind_err", int'(step_err), int'(e.is_err));
          chk("pulse_bin_out", int'(bin_out), e.bin);
          chk("pulse_dir", int'(dir), e.dir);
          chk("pulse_locked", int'(locked), e.is_err ? 0 : 1);
          chk("pulse_err_cnt", int'(err_cnt), e.errs);
        end
      end
    end
  end

  // Watchdog keeps the run bounded.
  initial begin
    repeat (60000) @(posedge clk);
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int r;
    int v;
    model_reset();
    #1 chk_idle("reset");
    repeat (3) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    repeat (2) @(posedge clk);

    // Acquire upward from zero.
    for (int i = 1; i <= 7; i++) drive(i);
    #1;
    chk("t1_locked", int'(locked), 1);
    chk("t1_dir", int'(dir), 1);
    chk("t1_err_cnt", int'(err_cnt), 0);
    chk("t1_bin_out", int'(bin_out), 7);

    // Wrap across 0xFF -> 0x00.
    drive(8'hF8);
    for (int i = 8'hF9; i <= 8'hFF; i++) drive(i);
    drive(0);
    #1 chk("t2_bin_out", int'(bin_out), 0);

    // Illegal skip while locked at 0x10, then relock.
    for (int i = 1; i <= 16; i++) drive(i);
    drive(8'h12);
    #1;
    chk("t3_locked", int'(locked), 0);
    chk("t3_bin_out_hold", int'(bin_out), 8'h10);
    chk("t3_err_cnt", int'(err_cnt), 2);
    for (int i = 8'h13; i <= 8'h16; i++) drive(i);
    #1 chk("t3_relock_bin", int'(bin_out), 8'h16);

    // Lock downward, then reverse.
    drive(8'h20);
    for (int i = 8'h1F; i >= 8'h1B; i--) drive(i);
    #1;
    chk("t4_dir", int'(dir), 0);
    chk("t4_locked", int'(locked), 1);
    drive(8'h1C);
    #1 chk("t4_unlock", int'(locked), 0);

    // Repeated illegal jumps and relocks saturate the error counter.
    v = cur;
    for (int k = 0; k < 20; k++) begin
      for (int i = 1; i <= 4; i++) drive(v + i);
      v = (v + 4 + 64) & 255;
      drive(v);
    end
    #1 chk("t5_err_sat", int'(err_cnt), ERR_MAX);

    // Reset while locked at 0x40.
    drive(8'h3C);
    for (int i = 8'h3D; i <= 8'h40; i++) drive(i);
    #1 chk("t6_locked_pre", int'(locked), 1);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1 chk_idle("t6_reset");
    chk("t6_queue_empty", q.size(), 0);
    model_reset();
    @(negedge clk) rst_n = 1'b1;
    model_step(cur);
    repeat (3) @(posedge clk);
    for (int i = 8'h41; i <= 8'h43; i++) drive(i);
    #1 chk("t6_not_locked", int'(locked), 0);
    drive(8'h44);
    #1 chk("t6_relock_bin", int'(bin_out), 8'h44);

    // Random walk: mostly forward steps, some reversals and jumps.
    for (int n = 0; n < 400; n++) begin
      r = int'($urandom_range(0, 9));
      if (r < 7) v = m_dir ? cur + 1 : cur - 1;
      else if (r == 7) v = m_dir ? cur - 1 : cur + 1;
      else v = int'($urandom_range(0, 255));
      drive(v & 255);
    end

    repeat (5) @(posedge clk);
    #1;
    chk("final_queue_empty", q.size(), 0);
    chk("final_locked", int'(locked), m_locked);
    chk("final_err_cnt", int'(err_cnt), m_errs);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
